// File: rtl/cache_refill_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// cache_refill_controller: core-side lookup and miss sequencer for a write-through cache
// Revision 1.0 - initial release
// ----------------------------------------------------------------------------
module cache_refill_controller #(
  parameter int ADDR_SIZE  = 32,
  parameter int BLOCK_SIZE = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_SIZE-1:0]  req_addr,
  input  logic                  req_write,
  input  logic [BLOCK_SIZE-1:0] req_wdata,
  output logic                  rsp_valid,
  output logic [BLOCK_SIZE-1:0] rsp_rdata,
  output logic [ADDR_SIZE-1:0]  cache_addr,
  output logic                  cache_write_enable,
  output logic [BLOCK_SIZE-1:0] cache_write_data,
  input  logic [BLOCK_SIZE-1:0] cache_read_data,
  input  logic                  cache_hit,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic                  mem_req_write,
  output logic [ADDR_SIZE-1:0]  mem_req_addr,
  output logic [BLOCK_SIZE-1:0] mem_req_wdata,
  input  logic                  mem_rsp_valid,
  input  logic [BLOCK_SIZE-1:0] mem_rsp_rdata,
  output logic [CNT_WIDTH-1:0]  hit_count,
  output logic [CNT_WIDTH-1:0]  miss_count
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOOKUP   = 3'd1,
    S_MEM_REQ  = 3'd2,
    S_MEM_WAIT = 3'd3,
    S_FILL     = 3'd4,
    S_RESPOND  = 3'd5
  } state_e;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  state_e                state_q, state_d;
  logic [ADDR_SIZE-1:0]  addr_q, addr_d;
  logic [BLOCK_SIZE-1:0] wdata_q, wdata_d;
  logic                  write_q, write_d;
  logic [BLOCK_SIZE-1:0] fill_q, fill_d;
  logic [BLOCK_SIZE-1:0] rdata_q, rdata_d;
  logic [CNT_WIDTH-1:0]  hit_q, hit_d;
  logic [CNT_WIDTH-1:0]  miss_q, miss_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wdata_q <= '0;
      write_q <= 1'b0;
      fill_q  <= '0;
      rdata_q <= '0;
      hit_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      write_q <= write_d;
      fill_q  <= fill_d;
      rdata_q <= rdata_d;
      hit_q   <= hit_d;
      miss_q  <= miss_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    addr_d             = addr_q;
    wdata_d            = wdata_q;
    write_d            = write_q;
    fill_d             = fill_q;
    rdata_d            = rdata_q;
    hit_d              = hit_q;
    miss_d             = miss_q;
    req_ready          = 1'b0;
    rsp_valid          = 1'b0;
    cache_write_enable = 1'b0;
    cache_write_data   = '0;
    mem_req_valid      = 1'b0;
    mem_req_write      = 1'b0;
    mem_req_addr       = '0;
    mem_req_wdata      = '0;

    unique case (state_q)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          addr_d  = req_addr;
          write_d = req_write;
          wdata_d = req_wdata;
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (cache_hit) begin
          if (hit_q != CNT_MAX) hit_d = hit_q + CNT_ONE;
          if (write_q) begin
            // Store hit updates the cached copy now; memory is written next.
            cache_write_enable = 1'b1;
            cache_write_data   = wdata_q;
            state_d            = S_MEM_REQ;
          end else begin
            rdata_d = cache_read_data;
            state_d = S_RESPOND;
          end
        end else begin
          if (miss_q != CNT_MAX) miss_d = miss_q + CNT_ONE;
          state_d = S_MEM_REQ;
        end
      end
      S_MEM_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = write_q;
        mem_req_addr  = addr_q;
        mem_req_wdata = write_q ? wdata_q : '0;
        if (mem_req_ready) state_d = S_MEM_WAIT;
      end
      S_MEM_WAIT: begin
        if (mem_rsp_valid) begin
          if (write_q) begin
            state_d = S_RESPOND;
          end else begin
            fill_d  = mem_rsp_rdata;
            state_d = S_FILL;
          end
        end
      end
      S_FILL: begin
        cache_write_enable = 1'b1;
        cache_write_data   = fill_q;
        rdata_d            = fill_q;
        state_d            = S_RESPOND;
      end
      S_RESPOND: begin
        rsp_valid = 1'b1;
        rdata_d   = '0;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign cache_addr = (state_q == S_IDLE) ? '0 : addr_q;
  assign rsp_rdata  = rdata_q;
  assign hit_count  = hit_q;
  assign miss_count = miss_q;

endmodule
`default_nettype wire

// File: doc/cache_refill_controller.md
Name: cache_refill_controller

Overview:
- Sequencing controller between a single-port core load/store interface and the two-way LRU cache plus backing memory.
- Performs the cache lookup and handles misses: issues a memory read, then writes the returned block into the cache; the cache's own controller and LRU logic choose the victim way.
- Write policy is write-through, with no write-allocate on store misses.
- Maintains saturating hit and miss counters for performance monitoring.

Parameters:
- ADDR_SIZE, 32, byte address width shared with the cache and memory.
- BLOCK_SIZE, 32, data width of one cache block and of one memory transfer.
- CNT_WIDTH, 16, width of the hit and miss statistics counters.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  core request present.
- req_ready  out  1  controller can accept a request.
- req_addr  in  ADDR_SIZE  request address.
- req_write  in  1  1 = store, 0 = load.
- req_wdata  in  BLOCK_SIZE  store data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  BLOCK_SIZE  load data; 0 for stores.
- cache_addr  out  ADDR_SIZE  address to the cache.
- cache_write_enable  out  1  cache write strobe.
- cache_write_data  out  BLOCK_SIZE  cache write data.
- cache_read_data  in  BLOCK_SIZE  cache combinational read data.
- cache_hit  in  1  cache combinational hit for cache_addr.
- mem_req_valid  out  1  memory request.
- mem_req_ready  in  1  memory accepts request.
- mem_req_write  out  1  memory request is a write.
- mem_req_addr  out  ADDR_SIZE  memory address.
- mem_req_wdata  out  BLOCK_SIZE  memory write data.
- mem_rsp_valid  in  1  memory completion; carries read data for reads, acts as write ack for writes.
- mem_rsp_rdata  in  BLOCK_SIZE  memory read data.
- hit_count  out  CNT_WIDTH  saturating lookup-hit count.
- miss_count  out  CNT_WIDTH  saturating lookup-miss count.

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE.
  - Latched addr, wdata, write flag and fill data clear to 0.
  - All outputs are 0 except req_ready=1.
  - Counters clear to 0.
  - Reset mid-operation abandons any in-flight memory transaction without completing it; memory is reset alongside.
- All outputs are registered or decoded from state only; none depend combinationally on req_valid.
- cache_addr always drives the latched address; it is 0 in IDLE.
- IDLE:
  - req_ready=1.
  - On req_valid=1, latch addr, write and wdata, then go to LOOKUP.
- LOOKUP (exactly one cycle):
  - Sample cache_hit and increment hit_count or miss_count.
  - Load hit: latch cache_read_data into rsp_rdata, go to RESPOND.
  - Store hit: assert cache_write_enable=1 with cache_write_data=wdata in this cycle, go to MEM_REQ.
  - Load miss or store miss: go to MEM_REQ; the cache is not written.
- MEM_REQ:
  - mem_req_valid=1; mem_req_addr, mem_req_write and mem_req_wdata are held stable until mem_req_ready=1.
  - On the ready cycle, go to MEM_WAIT.
  - mem_req_wdata is 0 for reads.
- MEM_WAIT:
  - Wait for mem_rsp_valid.
  - Load: latch mem_rsp_rdata, go to FILL.
  - Store: go to RESPOND.
  - No timeout.
- FILL (one cycle):
  - cache_write_enable=1, cache_write_data=fill data.
  - Latch fill data into rsp_rdata, go to RESPOND.
- RESPOND (one cycle):
  - rsp_valid=1 with rsp_rdata.
  - The core cannot stall the response.
  - Next state is IDLE; rsp_rdata returns to 0 after the pulse.
- Latency, with acceptance at cycle T:
  - Load hit: rsp_valid at T+2.
  - Load miss, with memory ready in the same cycle and response one cycle later: rsp_valid at T+5.
- Boundary and corner rules:
  - mem_rsp_valid outside MEM_WAIT is ignored.
  - req_valid outside IDLE is ignored; the request stays pending on the core side.
  - A mem_rsp_valid in the same cycle as mem_req_ready is not consumed; the response must arrive at least one cycle later.
  - Counters saturate at all-ones and do not wrap.
  - A store hit and a load in back-to-back requests: the load's LOOKUP observes the stored data.

Test Plan:
- Reset check: rst pulse -> req_ready=1, all other outputs 0, counters 0.
- Cold load, then reload of addr 0x40: first load misses; memory returns 0xDEADBEEF; mem_req_write=0; one cycle of cache_write_enable with 0xDEADBEEF; rsp_rdata=0xDEADBEEF; miss_count=1. Second load of 0x40 -> rsp_valid at T+2 with 0xDEADBEEF, no mem_req_valid, hit_count=1.
- Store miss to 0x80, data 0x12345678: mem_req_write=1 with that data; cache_write_enable never asserts. A following load of 0x80 misses.
- Store hit to 0x40, data 0xA5A5A5A5: cache_write_enable asserts in LOOKUP and a memory write follows. A subsequent load of 0x40 hits and returns 0xA5A5A5A5.
- Memory backpressure: mem_req_ready held low 5 cycles -> mem_req_valid and address stay stable for all 6 cycles; a spurious mem_rsp_valid during MEM_REQ is ignored.
- Reset asserted while in MEM_WAIT -> immediate return to IDLE, rsp_valid never pulses, counters are 0. With hit_count forced to 0xFFFF, a further hit keeps it at 0xFFFF.
